complex_div: RTL and testbench

Sequential fixed-point complex divider: computes Q = A / B for A = ar + j·ai and B = br + j·bi.
- Algorithm: (A·conj(B)) / |B|², using one shared signed multiplier and two parallel restoring dividers, one for the real part and one for the imaginary part.
- Role: the inverse-direction companion of the complex multiply/add datapath. It lets results of complex products be normalised back into the same Q-format word.
- Control: start/busy/done handshake; stalled by `ce` like the rest of the arithmetic blocks.

---
 rtl/complex_div.sv | 182 ++++++++++++++++++
 tb/tb_complex_div.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/complex_div.sv
// Sequential fixed-point complex divider: Q = (A * conj(B)) / |B|^2 with one shared
// signed multiplier and two parallel restoring dividers; fixed latency, ce-stallable.
module complex_div #(
  parameter int W    = 18,
  parameter int FRAC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                start,
  input  logic signed [W-1:0] ar,
  input  logic signed [W-1:0] ai,
  input  logic signed [W-1:0] br,
  input  logic signed [W-1:0] bi,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] qr,
  output logic signed [W-1:0] qi,
  output logic                ovf,
  output logic                div_zero
);

  localparam int AW = 2*W + 1;
  localparam int XW = 4*W;
  localparam int QW = W - 1;
  localparam int CW = $clog2(W);

  // state | meaning
  // IDLE  | wait for start, latch operands
  // MUL0-5| shared multiplier, one product per cycle (registered)
  // ACC   | fold last product into D
  // CHK   | signs, magnitudes, div-by-zero and overflow flags
  // DIV   | W-1 restoring iterations, both components in parallel
  // OUT   | done pulse, results visible
  typedef enum logic [3:0] {
    S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_MUL4, S_MUL5,
    S_ACC, S_CHK, S_DIV, S_OUT
  } state_t;

  state_t                 state;
  logic signed [W-1:0]    op_ar, op_ai, op_br, op_bi;
  logic signed [2*W-1:0]  prod;
  logic signed [AW-1:0]   nr, ni, d;
  logic                   sign_r, sign_i, ovf_r, ovf_i, dz;
  logic        [XW-1:0]   rem_r, rem_i, dsh;
  logic        [QW-1:0]   quo_r, quo_i;
  logic        [CW-1:0]   cnt;

  logic signed [W-1:0]    mul_a, mul_b;
  logic signed [2*W-1:0]  mul_p;
  logic signed [AW-1:0]   prod_x;
  logic        [AW-1:0]   mag_nr, mag_ni;
  logic        [XW-1:0]   num_r, num_i, den_lim;
  logic                   trial_r, trial_i;
  logic        [XW-1:0]   rem_r_nxt, rem_i_nxt;
  logic        [QW-1:0]   quo_r_nxt, quo_i_nxt;

  always_comb begin
    mul_a = op_ar;
    mul_b = op_br;
    case (state)
      S_MUL1:  begin mul_a = op_ai; mul_b = op_bi; end
      S_MUL2:  begin mul_a = op_ai; mul_b = op_br; end
      S_MUL3:  begin mul_a = op_ar; mul_b = op_bi; end
      S_MUL4:  begin mul_a = op_br; mul_b = op_br; end
      S_MUL5:  begin mul_a = op_bi; mul_b = op_bi; end
      default: begin mul_a = op_ar; mul_b = op_br; end
    endcase
  end

  assign mul_p  = mul_a * mul_b;
  assign prod_x = AW'(prod);

  assign mag_nr  = nr[AW-1] ? AW'(-nr) : AW'(nr);
  assign mag_ni  = ni[AW-1] ? AW'(-ni) : AW'(ni);
  assign num_r   = XW'(mag_nr) << FRAC;
  assign num_i   = XW'(mag_ni) << FRAC;
  assign den_lim = XW'($unsigned(d)) << (W-1);

  // Long division against a right-shifting divisor; no-overflow guarantees W-1 bits suffice.
  assign trial_r   = rem_r >= dsh;
  assign trial_i   = rem_i >= dsh;
  assign rem_r_nxt = trial_r ? rem_r - dsh : rem_r;
  assign rem_i_nxt = trial_i ? rem_i - dsh : rem_i;
  assign quo_r_nxt = {quo_r[QW-2:0], trial_r};
  assign quo_i_nxt = {quo_i[QW-2:0], trial_i};

  function automatic logic [W-1:0] finish_q(input logic neg, input logic sat,
                                            input logic [QW-1:0] q);
    logic [W-1:0] m;
    m = sat ? {1'b0, {QW{1'b1}}} : {1'b0, q};
    return neg ? W'(-m) : m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_ar    <= '0;
      op_ai    <= '0;
      op_br    <= '0;
      op_bi    <= '0;
      prod     <= '0;
      nr       <= '0;
      ni       <= '0;
      d        <= '0;
      sign_r   <= 1'b0;
      sign_i   <= 1'b0;
      ovf_r    <= 1'b0;
      ovf_i    <= 1'b0;
      dz       <= 1'b0;
      rem_r    <= '0;
      rem_i    <= '0;
      dsh      <= '0;
      quo_r    <= '0;
      quo_i    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      qr       <= '0;
      qi       <= '0;
      ovf      <= 1'b0;
      div_zero <= 1'b0;
    end else if (ce) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_ar <= ar;
            op_ai <= ai;
            op_br <= br;
            op_bi <= bi;
            busy  <= 1'b1;
            state <= S_MUL0;
          end
        end
        S_MUL0: begin prod <= mul_p;                     state <= S_MUL1; end
        S_MUL1: begin prod <= mul_p; nr <= prod_x;       state <= S_MUL2; end
        S_MUL2: begin prod <= mul_p; nr <= nr + prod_x;  state <= S_MUL3; end
        S_MUL3: begin prod <= mul_p; ni <= prod_x;       state <= S_MUL4; end
        S_MUL4: begin prod <= mul_p; ni <= ni - prod_x;  state <= S_MUL5; end
        S_MUL5: begin prod <= mul_p; d  <= prod_x;       state <= S_ACC;  end
        S_ACC:  begin d <= d + prod_x;                   state <= S_CHK;  end
        S_CHK: begin
          sign_r <= nr[AW-1];
          sign_i <= ni[AW-1];
          dz     <= (d == '0);
          ovf_r  <= num_r >= den_lim;
          ovf_i  <= num_i >= den_lim;
          rem_r  <= num_r;
          rem_i  <= num_i;
          dsh    <= XW'($unsigned(d)) << (W-2);
          quo_r  <= '0;
          quo_i  <= '0;
          cnt    <= CW'(W-2);
          state  <= S_DIV;
        end
        S_DIV: begin
          rem_r <= rem_r_nxt;
          rem_i <= rem_i_nxt;
          quo_r <= quo_r_nxt;
          quo_i <= quo_i_nxt;
          dsh   <= dsh >> 1;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            qr       <= dz ? '0 : finish_q(sign_r, ovf_r, quo_r_nxt);
            qi       <= dz ? '0 : finish_q(sign_i, ovf_i, quo_i_nxt);
            ovf      <= ~dz & (ovf_r | ovf_i);
            div_zero <= dz;
            done     <= 1'b1;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// Self-checking bench for complex_div: directed cases plus random operands against
// an integer-arithmetic reference of the complex quotient.
module tb_complex_div;
  localparam int W    = 18;
  localparam int FRAC = 16;
  localparam longint LIM = (longint'(1) << (W-1)) - 1;

  logic                clk = 1'b0;
  logic                rst, ce, start;
  logic signed [W-1:0] ar, ai, br, bi;
  logic                busy, done, ovf, div_zero;
  logic signed [W-1:0] qr, qi;

  int errors = 0;
  int checks = 0;

  complex_div #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .busy(busy), .done(done), .qr(qr), .qi(qi),
    .ovf(ovf), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One quotient component: truncate magnitude, saturate symmetrically, reapply sign.
  function automatic void comp(input longint n, input longint dd,
                               output longint q, output bit o);
    longint mag, num;
    mag = (n < 0) ? -n : n;
    num = mag * (longint'(1) << FRAC);
    if (num >= dd * (longint'(1) << (W-1))) begin
      o = 1'b1;
      q = (n < 0) ? -LIM : LIM;
    end else begin
      o = 1'b0;
      q = num / dd;
      if (n < 0) q = -q;
    end
  endfunction

  function automatic void model(input longint a_r, a_i, b_r, b_i,
                                output longint eqr, eqi, output bit eovf, edz);
    longint nr, ni, dd;
    bit o_r, o_i;
    nr = a_r*b_r + a_i*b_i;
    ni = a_i*b_r - a_r*b_i;
    dd = b_r*b_r + b_i*b_i;
    if (dd == 0) begin
      eqr = 0; eqi = 0; eovf = 1'b0; edz = 1'b1;
    end else begin
      comp(nr, dd, eqr, o_r);
      comp(ni, dd, eqi, o_i);
      eovf = o_r | o_i;
      edz  = 1'b0;
    end
  endfunction

  task automatic run_op(input string tag,
                        input logic signed [W-1:0] a_r, a_i, b_r, b_i,
                        input int stall_at, input int stall_len, input bit extra_start);
    longint eqr, eqi;
    bit eovf, edz, seen;
    int cnt;
    model(longint'(a_r), longint'(a_i), longint'(b_r), longint'(b_i), eqr, eqi, eovf, edz);
    @(negedge clk);
    ar = a_r; ai = a_i; br = b_r; bi = b_i; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ar = W'($urandom); ai = W'($urandom); br = W'($urandom); bi = W'($urandom);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (extra_start) start = (cnt == 3);
      if (stall_len > 0 && cnt == stall_at) ce = 1'b0;
      if (stall_len > 0 && cnt == stall_at + stall_len) ce = 1'b1;
      if (cnt == 1) check({tag, "_busy_early"}, longint'(busy), 1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    ce = 1'b1;
    check({tag, "_latency"}, cnt, 25 + stall_len);
    check({tag, "_qr"}, longint'(qr), eqr);
    check({tag, "_qi"}, longint'(qi), eqi);
    check({tag, "_ovf"}, longint'(ovf), longint'(eovf));
    check({tag, "_dz"}, longint'(div_zero), longint'(edz));
    check({tag, "_busy_done"}, longint'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, longint'(done), 0);
    check({tag, "_busy_after"}, longint'(busy), 0);
  endtask

  initial begin
    logic signed [W-1:0] r_ar, r_ai, r_br, r_bi;
    int sa, sl;
    rst = 1'b1; ce = 1'b1; start = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_qr", longint'(qr), 0);
    check("rst_ovf", longint'(ovf), 0);
    rst = 1'b0;

    run_op("one_div_one", 18'sd65536, 18'sd65536, 18'sd65536, 18'sd65536, 0, 0, 1'b0);
    check("one_div_one_val", longint'(qr), 65536);
    run_op("one_div_j", 18'sd65536, 18'sd0, 18'sd0, 18'sd65536, 0, 0, 1'b0);
    check("one_div_j_val", longint'(qi), -65536);
    run_op("trunc_pos", 18'sd16384, 18'sd0, 18'sd49152, 18'sd0, 0, 0, 1'b0);
    check("trunc_pos_val", longint'(qr), 21845);
    run_op("trunc_neg", -18'sd16384, 18'sd0, 18'sd49152, 18'sd0, 0, 0, 1'b0);
    check("trunc_neg_val", longint'(qr), -21845);
    run_op("sat", 18'sd65536, 18'sd0, 18'sd32768, 18'sd0, 0, 0, 1'b0);
    check("sat_val", longint'(qr), 131071);
    run_op("sat_neg", -18'sd65536, 18'sd100, 18'sd1, 18'sd0, 0, 0, 1'b0);
    run_op("divzero", 18'sd12345, -18'sd777, 18'sd0, 18'sd0, 0, 0, 1'b0);
    check("divzero_flag", longint'(div_zero), 1);
    run_op("stall", 18'sd30000, -18'sd20000, 18'sd50000, 18'sd40000, 12, 5, 1'b0);
    run_op("ignore_start", 18'sd1000, 18'sd2000, 18'sd60000, -18'sd3000, 0, 0, 1'b1);
    @(negedge clk);
    check("no_queue_busy", longint'(busy), 0);

    run_op("pre_reset", 18'sd65536, 18'sd65536, 18'sd65536, 18'sd65536, 0, 0, 1'b0);
    @(negedge clk);
    ar = 18'sd5000; ai = 18'sd6000; br = 18'sd7000; bi = 18'sd8000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_qr", longint'(qr), 0);
    check("midrst_qi", longint'(qi), 0);
    check("midrst_flags", longint'({ovf, div_zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_reset", 18'sd5000, 18'sd6000, 18'sd7000, 18'sd8000, 0, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r_ar = W'($urandom);
      r_ai = W'($urandom);
      r_br = W'($urandom);
      r_bi = W'($urandom);
      if (i % 4 == 1) begin
        r_br = W'($signed($urandom_range(0, 2000)) - 1000);
        r_bi = W'($signed($urandom_range(0, 2000)) - 1000);
      end
      if (i % 8 == 5) begin
        r_br = '0;
        r_bi = '0;
      end
      sa = $urandom_range(2, 22);
      sl = (i % 3 == 0) ? $urandom_range(1, 3) : 0;
      run_op($sformatf("rand%0d", i), r_ar, r_ai, r_br, r_bi, sa, sl, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
